// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port byte-writable BRAM between the fetch
//               and data ports, with a data-priority starvation limit.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int RD_LATENCY   = 2,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    localparam logic [3:0] c_max_streak = 4'(MAX_D_STREAK);

    logic [3:0]            r_streak;
    logic                  w_if_gnt;
    logic                  w_d_gnt;
    logic                  w_rd_accept;
    logic                  w_ret_valid;
    logic [RD_LATENCY-1:0] r_valid;
    logic [RD_LATENCY-1:0] r_is_data;
    logic [RD_LATENCY-1:0] w_valid_nxt;
    logic [RD_LATENCY-1:0] w_is_data_nxt;

    // Data wins unless fetch has already waited through a full streak.
    always_comb begin
        w_d_gnt  = 1'b0;
        w_if_gnt = 1'b0;
        if (!rst) begin
            if (d_req && (!if_req || (r_streak != c_max_streak))) begin
                w_d_gnt = 1'b1;
            end else if (if_req) begin
                w_if_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= 4'd0;
        end else if (!if_req || w_if_gnt) begin
            r_streak <= 4'd0;
        end else if (w_d_gnt && (r_streak != c_max_streak)) begin
            r_streak <= r_streak + 4'd1;
        end
    end

    assign if_gnt = w_if_gnt;
    assign d_gnt  = w_d_gnt;

    always_comb begin
        ram_en   = w_if_gnt | w_d_gnt;
        ram_we   = (w_d_gnt && d_we) ? d_be : 4'b0000;
        ram_addr = w_d_gnt ? d_addr : (w_if_gnt ? if_addr : '0);
        ram_din  = w_d_gnt ? d_wdata : 32'd0;
    end

    assign w_rd_accept = w_if_gnt | (w_d_gnt & ~d_we);

    generate
        if (RD_LATENCY == 1) begin : g_single
            assign w_valid_nxt   = w_rd_accept;
            assign w_is_data_nxt = w_d_gnt;
        end else begin : g_shift
            assign w_valid_nxt   = {r_valid[RD_LATENCY-2:0], w_rd_accept};
            assign w_is_data_nxt = {r_is_data[RD_LATENCY-2:0], w_d_gnt};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= '0;
            r_is_data <= '0;
        end else begin
            r_valid   <= w_valid_nxt;
            r_is_data <= w_is_data_nxt;
        end
    end

    // Returns are suppressed while in reset so no pre-reset read ever surfaces.
    assign w_ret_valid = r_valid[RD_LATENCY-1] & ~rst;
    assign if_rvalid   = w_ret_valid & ~r_is_data[RD_LATENCY-1];
    assign d_rvalid    = w_ret_valid &  r_is_data[RD_LATENCY-1];
    assign if_rdata    = if_rvalid ? ram_dout : 32'd0;
    assign d_rdata     = d_rvalid  ? ram_dout : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench: vector table, directed corner sequences
//               and randomized traffic against a behavioural memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int   AW   = 11;
    localparam int   LAT  = 2;
    localparam int   MAXS = 4;
    localparam logic H    = 1'b1;
    localparam logic L    = 1'b0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr = '0;
    logic [31:0]   if_rdata;
    logic          d_req = 1'b0, d_we = 1'b0, d_gnt, d_rvalid;
    logic [3:0]    d_be = 4'h0;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_wdata = 32'd0, d_rdata;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din, ram_dout;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .RD_LATENCY(LAT), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Read-first byte-writable BRAM with LAT cycles of read latency.
    logic [31:0] bram  [0:(1<<AW)-1];
    logic [31:0] rpipe [0:LAT-1];
    always @(posedge clk) begin
        if (ram_en) begin
            rpipe[0] <= bram[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) bram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_dout = rpipe[LAT-1];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, ir, input logic [AW-1:0] ia, input logic dr, dwe,
                         input logic [3:0] dbe, input logic [AW-1:0] da, input logic [31:0] dwd);
        rst = r; if_req = ir; if_addr = ia; d_req = dr; d_we = dwe;
        d_be = dbe; d_addr = da; d_wdata = dwd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        drive(L, L, '0, L, L, 4'h0, '0, 32'd0);
    endtask

    typedef struct {
        logic r, ir, dr, dwe;
        logic [3:0] be;
        logic eig, edg, een;
        logic [3:0] ewe;
        logic eirv, edrv;
    } vec_t;

    function automatic vec_t mkv(input logic r, ir, dr, dwe, input logic [3:0] be,
                                 input logic eig, edg, een, input logic [3:0] ewe,
                                 input logic eirv, edrv);
        vec_t v;
        v.r = r; v.ir = ir; v.dr = dr; v.dwe = dwe; v.be = be;
        v.eig = eig; v.edg = edg; v.een = een; v.ewe = ewe;
        v.eirv = eirv; v.edrv = edrv;
        return v;
    endfunction

    // Behavioural reference for the randomized phase.
    typedef struct { int due; logic is_d; logic [31:0] data; } ret_t;
    ret_t        q[$];
    logic [31:0] shadow [0:7];
    int          m_streak = 0;
    int          cyc      = 0;

    task automatic rstep(input logic r, ir, input logic [AW-1:0] ia, input logic dr, dwe,
                         input logic [3:0] dbe, input logic [AW-1:0] da, input logic [31:0] dwd,
                         output logic gf, output logic gd);
        logic pd, pf, eirv, edrv;
        logic [31:0] edat;
        drive(r, ir, ia, dr, dwe, dbe, da, dwd);
        @(negedge clk);
        pd   = !r && dr && (!ir || m_streak < MAXS);
        pf   = !r && ir && !pd;
        eirv = 1'b0; edrv = 1'b0; edat = 32'd0;
        if (r) begin
            q.delete();
        end else if (q.size() > 0 && q[0].due == cyc) begin
            eirv = !q[0].is_d;
            edrv = q[0].is_d;
            edat = q[0].data;
            void'(q.pop_front());
        end
        chk("rnd_if_gnt", 32'(if_gnt), 32'(pf));
        chk("rnd_d_gnt", 32'(d_gnt), 32'(pd));
        chk("rnd_ram_en", 32'(ram_en), 32'(pf | pd));
        chk("rnd_ram_addr", 32'(ram_addr), pd ? 32'(da) : (pf ? 32'(ia) : 32'd0));
        chk("rnd_ram_we", 32'(ram_we), (pd && dwe) ? 32'(dbe) : 32'd0);
        chk("rnd_ram_din", ram_din, pd ? dwd : 32'd0);
        chk("rnd_if_rvalid", 32'(if_rvalid), 32'(eirv));
        chk("rnd_d_rvalid", 32'(d_rvalid), 32'(edrv));
        chk("rnd_if_rdata", if_rdata, eirv ? edat : 32'd0);
        chk("rnd_d_rdata", d_rdata, edrv ? edat : 32'd0);
        if (pf) q.push_back('{cyc + LAT, 1'b0, shadow[ia[2:0]]});
        if (pd && !dwe) q.push_back('{cyc + LAT, 1'b1, shadow[da[2:0]]});
        if (pd && dwe)
            for (int b = 0; b < 4; b++)
                if (dbe[b]) shadow[da[2:0]][8*b +: 8] = dwd[8*b +: 8];
        if (r || !ir || pf) m_streak = 0;
        else if (pd) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        gf = pf;
        gd = pd;
        tick();
        cyc++;
    endtask

    vec_t        tbl [20];
    logic        h_ir, h_dr, h_dwe, gf, gd, rr;
    logic [3:0]  h_be;
    logic [AW-1:0] h_ia, h_da;
    logic [31:0] h_wd;
    logic [31:0] il_data [3];

    initial begin
        // Reset with both requests, 12 contended cycles, then a store and a lone fetch.
        for (int i = 0; i < 3; i++) tbl[i] = mkv(H,H,H,L,4'h0, L,L,L,4'h0, L,L);
        tbl[3]  = mkv(L,H,H,L,4'h0, L,H,H,4'h0, L,L);
        tbl[4]  = mkv(L,H,H,L,4'h0, L,H,H,4'h0, L,L);
        tbl[5]  = mkv(L,H,H,L,4'h0, L,H,H,4'h0, L,H);
        tbl[6]  = mkv(L,H,H,L,4'h0, L,H,H,4'h0, L,H);
        tbl[7]  = mkv(L,H,H,L,4'h0, H,L,H,4'h0, L,H);
        tbl[8]  = mkv(L,H,H,L,4'h0, L,H,H,4'h0, L,H);
        tbl[9]  = mkv(L,H,H,L,4'h0, L,H,H,4'h0, H,L);
        tbl[10] = mkv(L,H,H,L,4'h0, L,H,H,4'h0, L,H);
        tbl[11] = mkv(L,H,H,L,4'h0, L,H,H,4'h0, L,H);
        tbl[12] = mkv(L,H,H,L,4'h0, H,L,H,4'h0, L,H);
        tbl[13] = mkv(L,H,H,L,4'h0, L,H,H,4'h0, L,H);
        tbl[14] = mkv(L,H,H,L,4'h0, L,H,H,4'h0, H,L);
        tbl[15] = mkv(L,L,H,H,4'h3, L,H,H,4'h3, L,H);
        tbl[16] = mkv(L,L,L,L,4'h0, L,L,L,4'h0, L,H);
        tbl[17] = mkv(L,L,L,L,4'h0, L,L,L,4'h0, L,L);
        tbl[18] = mkv(L,H,L,L,4'h0, H,L,H,4'h0, L,L);
        tbl[19] = mkv(L,H,H,L,4'h0, L,H,H,4'h0, L,L);

        tick();
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].r, tbl[i].ir, 11'h006, tbl[i].dr, tbl[i].dwe, tbl[i].be,
                  11'h005, 32'hCAFE_0000 + 32'(i));
            @(negedge clk);
            chk($sformatf("tbl%0d_if_gnt", i), 32'(if_gnt), 32'(tbl[i].eig));
            chk($sformatf("tbl%0d_d_gnt", i), 32'(d_gnt), 32'(tbl[i].edg));
            chk($sformatf("tbl%0d_ram_en", i), 32'(ram_en), 32'(tbl[i].een));
            chk($sformatf("tbl%0d_ram_we", i), 32'(ram_we), 32'(tbl[i].ewe));
            chk($sformatf("tbl%0d_if_rvalid", i), 32'(if_rvalid), 32'(tbl[i].eirv));
            chk($sformatf("tbl%0d_d_rvalid", i), 32'(d_rvalid), 32'(tbl[i].edrv));
            tick();
        end
        for (int i = 0; i < 3; i++) begin idle(); tick(); end

        // Fetch read of a word written through the data port.
        drive(L, L, '0, H, H, 4'hF, 11'h010, 32'hDEADBEEF);
        @(negedge clk); chk("pre_st_gnt", 32'(d_gnt), 32'd1); tick();
        drive(L, H, 11'h010, L, L, 4'h0, '0, 32'd0);
        @(negedge clk);
        chk("fr_gnt", 32'(if_gnt), 32'd1);
        chk("fr_addr", 32'(ram_addr), 32'h010);
        tick();
        for (int k = 1; k <= LAT; k++) begin
            idle(); @(negedge clk);
            chk("fr_if_rvalid", 32'(if_rvalid), (k == LAT) ? 32'd1 : 32'd0);
            chk("fr_if_rdata", if_rdata, (k == LAT) ? 32'hDEADBEEF : 32'd0);
            chk("fr_d_rvalid", 32'(d_rvalid), 32'd0);
            tick();
        end

        // Partial store followed immediately by a load of the same word.
        drive(L, L, '0, H, H, 4'hF, 11'h020, 32'hAAAAAAAA); tick();
        drive(L, L, '0, H, H, 4'h3, 11'h020, 32'h12345678);
        @(negedge clk); chk("sl_st_we", 32'(ram_we), 32'h3); tick();
        drive(L, L, '0, H, L, 4'h0, 11'h020, 32'd0);
        @(negedge clk); chk("sl_ld_gnt", 32'(d_gnt), 32'd1); tick();
        for (int k = 1; k <= LAT; k++) begin
            idle(); @(negedge clk);
            chk("sl_d_rvalid", 32'(d_rvalid), (k == LAT) ? 32'd1 : 32'd0);
            chk("sl_d_rdata", d_rdata, (k == LAT) ? 32'hAAAA5678 : 32'd0);
            chk("sl_if_rvalid", 32'(if_rvalid), 32'd0);
            tick();
        end

        // Interleaved F, D, F reads return in order on consecutive cycles.
        il_data[0] = 32'h11111111; il_data[1] = 32'h22222222; il_data[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            drive(L, L, '0, H, H, 4'hF, 11'h030 + 11'(i), il_data[i]); tick();
        end
        for (int k = 0; k < LAT + 3; k++) begin
            if (k == 0)      drive(L, H, 11'h030, L, L, 4'h0, '0, 32'd0);
            else if (k == 1) drive(L, L, '0, H, L, 4'h0, 11'h031, 32'd0);
            else if (k == 2) drive(L, H, 11'h032, L, L, 4'h0, '0, 32'd0);
            else             idle();
            @(negedge clk);
            if (k < 3) chk("il_gnt", 32'({if_gnt, d_gnt}), (k == 1) ? 32'h1 : 32'h2);
            if (k >= LAT) begin
                chk("il_if_rvalid", 32'(if_rvalid), (k - LAT == 1) ? 32'd0 : 32'd1);
                chk("il_d_rvalid", 32'(d_rvalid), (k - LAT == 1) ? 32'd1 : 32'd0);
                chk("il_rdata", if_rdata | d_rdata, il_data[k - LAT]);
            end
            tick();
        end

        // Reset right after an accepted read, with a store presented during reset.
        drive(L, H, 11'h010, L, L, 4'h0, '0, 32'd0);
        @(negedge clk); chk("rm_gnt", 32'(if_gnt), 32'd1); tick();
        drive(H, L, '0, H, H, 4'hF, 11'h010, 32'h0);
        @(negedge clk);
        chk("rm_rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rm_rst_ram_en", 32'(ram_en), 32'd0);
        chk("rm_rst_ram_we", 32'(ram_we), 32'd0);
        tick();
        for (int k = 0; k < LAT + 2; k++) begin
            idle(); @(negedge clk);
            chk("rm_if_rvalid", 32'(if_rvalid), 32'd0);
            chk("rm_d_rvalid", 32'(d_rvalid), 32'd0);
            chk("rm_if_rdata", if_rdata, 32'd0);
            tick();
        end
        drive(L, L, '0, H, L, 4'h0, 11'h010, 32'd0); tick();
        for (int k = 1; k <= LAT; k++) begin
            idle(); @(negedge clk);
            if (k == LAT) chk("rm_store_dropped", d_rdata, 32'hDEADBEEF);
            tick();
        end

        // Randomized traffic against the reference model.
        rstep(H, L, '0, L, L, 4'h0, '0, 32'd0, gf, gd);
        for (int i = 0; i < 8; i++)
            rstep(L, L, '0, H, H, 4'hF, 11'h040 + 11'(i), $urandom, gf, gd);
        h_ir = 1'b0; h_dr = 1'b0; gf = 1'b0; gd = 1'b0;
        h_ia = 11'h040; h_da = 11'h040; h_dwe = 1'b0; h_be = 4'h0; h_wd = 32'd0;
        for (int n = 0; n < 800; n++) begin
            if (!h_ir || gf) begin
                h_ir = ($urandom_range(0, 99) < 60);
                h_ia = 11'h040 + 11'($urandom_range(0, 7));
            end
            if (!h_dr || gd) begin
                h_dr  = ($urandom_range(0, 99) < 60);
                h_dwe = ($urandom_range(0, 2) == 0);
                h_be  = 4'($urandom_range(0, 15));
                h_da  = 11'h040 + 11'($urandom_range(0, 7));
                h_wd  = $urandom;
            end
            rr = ($urandom_range(0, 49) == 0);
            rstep(rr, h_ir, h_ia, h_dr, h_dwe, h_be, h_da, h_wd, gf, gd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
